// File: rtl/intra_neighbour_buffer_pkg.sv
// Shared types and helpers for the intra neighbour buffer.
package intra_pkg;

    // Value substituted for any neighbour pixel that lies outside the frame.
    localparam logic [7:0] DEFAULT_PIXEL = 8'd128;

    typedef enum logic [1:0] {
        PRESENT  = 2'd0,
        WAIT_BLK = 2'd1,
        UPDATE   = 2'd2
    } nb_state_t;

    function automatic int mbs_x(input int width, input int mb_w);
        return width / mb_w;
    endfunction

    function automatic int mbs_y(input int length, input int mb_l);
        return length / mb_l;
    endfunction

    // Index width that never collapses to zero bits for a single-MB axis.
    function automatic int idx_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/intra_neighbour_buffer_if.sv
// Neighbour/block exchange between the buffer and the intra prediction stage.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and its payload stable until that edge; ready
// may be high or low independently of valid.
//  - nb_valid/nb_ready  : buffer -> consumer, payload toppixels/leftpixels/mb_x/mb_y
//  - blk_valid/blk_ready: consumer -> buffer, payload blk_pixels
interface intra_neighbour_buffer_if
    import intra_pkg::*;
#(
    parameter int WIDTH     = 1280,
    parameter int LENGTH    = 720,
    parameter int MB_SIZE_L = 16,
    parameter int MB_SIZE_W = 16
);
    localparam int TOP_N  = (MB_SIZE_W == 4) ? 8 : MB_SIZE_W;
    localparam int LEFT_N = (MB_SIZE_L == 4) ? 5 : MB_SIZE_L;
    localparam int XW     = idx_bits(mbs_x(WIDTH, MB_SIZE_W));
    localparam int YW     = idx_bits(mbs_y(LENGTH, MB_SIZE_L));

    logic                                nb_valid;
    logic                                nb_ready;
    logic [TOP_N-1:0][7:0]               toppixels;
    logic [LEFT_N-1:0][7:0]              leftpixels;
    logic [XW-1:0]                       mb_x;
    logic [YW-1:0]                       mb_y;
    logic                                blk_valid;
    logic                                blk_ready;
    logic [MB_SIZE_L*MB_SIZE_W-1:0][7:0] blk_pixels;
    logic                                frame_done;

    // The buffer side.
    modport master (
        output nb_valid, toppixels, leftpixels, mb_x, mb_y, blk_ready, frame_done,
        input  nb_ready, blk_valid, blk_pixels
    );

    // The prediction/reconstruction side.
    modport slave (
        input  nb_valid, toppixels, leftpixels, mb_x, mb_y, blk_ready, frame_done,
        output nb_ready, blk_valid, blk_pixels
    );

endinterface

// File: rtl/intra_neighbour_buffer_linebuf.sv
// Frame-width line buffer holding the bottom row of the previous MB row.
// Read bundle layout: [0..W-1] pixels above MB x; then, for 4-wide MBs, the
// four pixels above MB x+1; then, for 4-high MBs, pixel x*W+W-1 (corner source).
module nbr_linebuf
    import intra_pkg::*;
#(
    parameter int WIDTH     = 1280,
    parameter int MB_SIZE_W = 16,
    parameter int XW        = 7,
    parameter bit TR_EN     = 1'b0,
    parameter bit LAST_EN   = 1'b0,
    parameter int RD_N      = 16
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [XW-1:0]               x,
    input  logic [MB_SIZE_W-1:0][7:0]   wdata,
    output logic [RD_N-1:0][7:0]        rd
);
    logic [7:0]                 mem [WIDTH];
    logic [MB_SIZE_W-1:0][7:0]  rd_main;

    // Slice write of one MB's bottom row; no reset, unavailable rows are masked downstream.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int p = 0; p < WIDTH; p++) begin
                if (p / MB_SIZE_W == int'(x)) begin
                    mem[p] <= wdata[p % MB_SIZE_W];
                end
            end
        end
    end

    // W-wide read of the row above the current MB.
    always_comb begin
        rd_main = '0;
        for (int p = 0; p < WIDTH; p++) begin
            if (p / MB_SIZE_W == int'(x)) begin
                rd_main[p % MB_SIZE_W] = mem[p];
            end
        end
    end

    assign rd[MB_SIZE_W-1:0] = rd_main;

    if (TR_EN) begin : g_tr
        logic [3:0][7:0] rd_tr;

        // 4-wide read above the next MB; reads zero past the frame edge (masked later).
        always_comb begin
            rd_tr = '0;
            for (int p = 0; p < WIDTH; p++) begin
                if (p / MB_SIZE_W == int'(x) + 1) begin
                    rd_tr[p % MB_SIZE_W] = mem[p];
                end
            end
        end

        assign rd[MB_SIZE_W+3:MB_SIZE_W] = rd_tr;
    end

    if (LAST_EN) begin : g_last
        logic [7:0] rd_last;

        // Right-most pixel above the current MB: becomes the next MB's corner.
        always_comb begin
            rd_last = '0;
            for (int p = 0; p < WIDTH; p++) begin
                if (p == int'(x) * MB_SIZE_W + MB_SIZE_W - 1) begin
                    rd_last = mem[p];
                end
            end
        end

        assign rd[RD_N-1] = rd_last;
    end

endmodule

// File: rtl/intra_neighbour_buffer.sv
// Presents top/left neighbour context per MB in raster order and captures each
// reconstructed MB to build the context of the following MBs.
module intra_neighbour_buffer
    import intra_pkg::*;
#(
    parameter int WIDTH     = 1280,
    parameter int LENGTH    = 720,
    parameter int MB_SIZE_L = 16,
    parameter int MB_SIZE_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    intra_neighbour_buffer_if.master  bus,
    output nb_state_t                 state_dbg
);
    localparam int W      = MB_SIZE_W;
    localparam int L      = MB_SIZE_L;
    localparam int MBS_X  = mbs_x(WIDTH, W);
    localparam int MBS_Y  = mbs_y(LENGTH, L);
    localparam int XW     = idx_bits(MBS_X);
    localparam int YW     = idx_bits(MBS_Y);
    localparam int RD_N   = W + ((W == 4) ? 4 : 0) + ((L == 4) ? 1 : 0);
    localparam logic [XW-1:0] LAST_X = XW'(MBS_X - 1);
    localparam logic [YW-1:0] LAST_Y = YW'(MBS_Y - 1);

    nb_state_t           state;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;
    logic [L-1:0][7:0]   left_col;
    logic                nb_valid_q;
    logic                blk_ready_q;
    logic                frame_done_q;

    logic                accept;
    logic                top_avail;
    logic                left_avail;
    logic [W-1:0][7:0]   bottom_row;
    logic [L-1:0][7:0]   right_col;
    logic [RD_N-1:0][7:0] rd;
    logic [W-1:0][7:0]   top_main;
    logic [L-1:0][7:0]   left_sel;

    assign accept     = (state == WAIT_BLK) && bus.blk_valid;
    assign top_avail  = (y != '0);
    assign left_avail = (x != '0);

    // Slice the incoming block into the bottom row and the right column.
    always_comb begin
        bottom_row = '0;
        right_col  = '0;
        for (int c = 0; c < W; c++) begin
            bottom_row[c] = bus.blk_pixels[(L - 1) * W + c];
        end
        for (int r = 0; r < L; r++) begin
            right_col[r] = bus.blk_pixels[r * W + W - 1];
        end
    end

    nbr_linebuf #(
        .WIDTH     (WIDTH),
        .MB_SIZE_W (W),
        .XW        (XW),
        .TR_EN     (W == 4),
        .LAST_EN   (L == 4),
        .RD_N      (RD_N)
    ) u_linebuf (
        .clk   (clk),
        .we    (accept),
        .x     (x),
        .wdata (bottom_row),
        .rd    (rd)
    );

    // Handshake FSM with MB position, left column and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= PRESENT;
            x            <= '0;
            y            <= '0;
            left_col     <= {L{DEFAULT_PIXEL}};
            nb_valid_q   <= 1'b1;
            blk_ready_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            case (state)
                PRESENT: begin
                    frame_done_q <= 1'b0;
                    if (bus.nb_ready) begin
                        state       <= WAIT_BLK;
                        nb_valid_q  <= 1'b0;
                        blk_ready_q <= 1'b1;
                    end
                end
                WAIT_BLK: begin
                    if (bus.blk_valid) begin
                        state       <= UPDATE;
                        blk_ready_q <= 1'b0;
                        left_col    <= right_col;
                        if (x == LAST_X) begin
                            x        <= '0;
                            left_col <= {L{DEFAULT_PIXEL}};
                            if (y == LAST_Y) begin
                                y            <= '0;
                                frame_done_q <= 1'b1;
                            end else begin
                                y <= y + 1'b1;
                            end
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                UPDATE: begin
                    state        <= PRESENT;
                    nb_valid_q   <= 1'b1;
                    frame_done_q <= 1'b0;
                end
                default: begin
                    state        <= PRESENT;
                    nb_valid_q   <= 1'b1;
                    blk_ready_q  <= 1'b0;
                    frame_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Mask the row above and the left column with their availability.
    always_comb begin
        top_main = '0;
        left_sel = '0;
        for (int i = 0; i < W; i++) begin
            top_main[i] = top_avail ? rd[i] : DEFAULT_PIXEL;
        end
        for (int i = 0; i < L; i++) begin
            left_sel[i] = left_avail ? left_col[i] : DEFAULT_PIXEL;
        end
    end

    if (W == 4) begin : g_top_right
        logic [3:0][7:0] top_right;

        // Top-right: next MB's row above, or replicate pixel 3 in the last column.
        always_comb begin
            top_right = '0;
            for (int j = 0; j < 4; j++) begin
                if (!top_avail) begin
                    top_right[j] = DEFAULT_PIXEL;
                end else if (x == LAST_X) begin
                    top_right[j] = rd[3];
                end else begin
                    top_right[j] = rd[W + j];
                end
            end
        end

        assign bus.toppixels = {top_right, top_main};
    end else begin : g_top_plain
        assign bus.toppixels = top_main;
    end

    if (L == 4) begin : g_corner
        logic [7:0] corner;

        // Corner captured before the line buffer overwrite; reset to default on a row wrap.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                corner <= DEFAULT_PIXEL;
            end else if (accept) begin
                corner <= (x == LAST_X || y == '0) ? DEFAULT_PIXEL : rd[RD_N-1];
            end
        end

        assign bus.leftpixels = {left_sel, (left_avail && top_avail) ? corner : DEFAULT_PIXEL};
    end else begin : g_left_plain
        assign bus.leftpixels = left_sel;
    end

    assign bus.nb_valid   = nb_valid_q;
    assign bus.blk_ready  = blk_ready_q;
    assign bus.frame_done = frame_done_q;
    assign bus.mb_x       = x;
    assign bus.mb_y       = y;
    assign state_dbg      = state;

endmodule

// File: tb/tb_intra_neighbour_buffer.sv
// Directed bench for the neighbour buffer in a 16x8 frame of 4x4 MBs (4x2 MBs).
// Block k carries pixel n = 16*k + n.
module tb_intra_neighbour_buffer;
    import intra_pkg::*;

    localparam int WIDTH  = 16;
    localparam int LENGTH = 8;
    localparam int L      = 4;
    localparam int W      = 4;

    logic      clk = 1'b0;
    logic      reset = 1'b0;
    nb_state_t state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [63:0] TOP_DEF  = {8{8'd128}};
    localparam logic [63:0] LEFT_DEF = {24'd0, {5{8'd128}}};

    always #5 clk = ~clk;

    intra_neighbour_buffer_if #(
        .WIDTH(WIDTH), .LENGTH(LENGTH), .MB_SIZE_L(L), .MB_SIZE_W(W)
    ) bus ();

    intra_neighbour_buffer #(
        .WIDTH(WIDTH), .LENGTH(LENGTH), .MB_SIZE_L(L), .MB_SIZE_W(W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Four pixels, element 0 in the low byte.
    function automatic logic [31:0] p4(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [L*W-1:0][7:0] make_blk(input int k);
        logic [L*W-1:0][7:0] b;
        for (int n = 0; n < L * W; n++) begin
            b[n] = 8'(16 * k + n);
        end
        return b;
    endfunction

    // One full MB exchange; returns at the negedge after nb_valid is expected back.
    task automatic send_block(input int k, input logic exp_fd);
        int t;
        t = 0;
        while (bus.nb_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("nb_valid_wait", bus.nb_valid, 1'b1);
        bus.nb_ready = 1'b1;
        @(negedge clk);
        bus.nb_ready = 1'b0;
        check("blk_ready_wait", bus.blk_ready, 1'b1);
        bus.blk_pixels = make_blk(k);
        bus.blk_valid  = 1'b1;
        @(negedge clk);
        bus.blk_valid = 1'b0;
        check("update_nb_valid", bus.nb_valid, 1'b0);
        check("frame_done", bus.frame_done, exp_fd);
        @(negedge clk);
        check("latency_nb_valid", bus.nb_valid, 1'b1);
        check("frame_done_low", bus.frame_done, 1'b0);
    endtask

    task automatic check_mb(input string tag, input int ex, input int ey,
                            input logic [63:0] etop, input logic [63:0] eleft);
        check({tag, "_mb_x"}, bus.mb_x, ex);
        check({tag, "_mb_y"}, bus.mb_y, ey);
        check({tag, "_top"}, bus.toppixels, etop);
        check({tag, "_left"}, bus.leftpixels, eleft);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.nb_ready   = 1'b0;
        bus.blk_valid  = 1'b0;
        bus.blk_pixels = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Reset state: MB(0,0) with all defaults.
        check("rst_nb_valid", bus.nb_valid, 1'b1);
        check("rst_blk_ready", bus.blk_ready, 1'b0);
        check("rst_frame_done", bus.frame_done, 1'b0);
        check("rst_state", state_dbg, PRESENT);
        check_mb("rst", 0, 0, TOP_DEF, LEFT_DEF);

        // Block 0 -> MB(1,0): left column from block 0, no row above yet.
        send_block(0, 1'b0);
        check_mb("mb10", 1, 0, TOP_DEF, {24'd0, p4(3, 7, 11, 15), 8'd128});

        // Rest of row 0 -> MB(0,1): row above from blocks 0 and 1.
        send_block(1, 1'b0);
        send_block(2, 1'b0);
        send_block(3, 1'b0);
        check_mb("mb01", 0, 1, {p4(28, 29, 30, 31), p4(12, 13, 14, 15)}, LEFT_DEF);

        // Block 4 -> MB(1,1): corner from block 0 pixel 15.
        send_block(4, 1'b0);
        check_mb("mb11", 1, 1, {p4(44, 45, 46, 47), p4(28, 29, 30, 31)},
                 {24'd0, p4(67, 71, 75, 79), 8'd15});

        // MB(3,1): last column replicates top[3] into top-right.
        send_block(5, 1'b0);
        send_block(6, 1'b0);
        check_mb("mb31", 3, 1, {p4(63, 63, 63, 63), p4(60, 61, 62, 63)},
                 {24'd0, p4(99, 103, 107, 111), 8'd47});

        // Last MB: frame_done pulse, wrap to MB(0,0) with defaults.
        send_block(7, 1'b1);
        check_mb("wrap", 0, 0, TOP_DEF, LEFT_DEF);

        // Move to MB(1,0) of the new frame, then stall there with a stray block.
        send_block(8, 1'b0);
        check_mb("mb10b", 1, 0, TOP_DEF, {24'd0, p4(131, 135, 139, 143), 8'd128});
        bus.blk_pixels = make_blk(9);
        bus.blk_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_nb_valid", bus.nb_valid, 1'b1);
            check("hold_blk_ready", bus.blk_ready, 1'b0);
            check("hold_state", state_dbg, PRESENT);
            check_mb("hold", 1, 0, TOP_DEF, {24'd0, p4(131, 135, 139, 143), 8'd128});
        end
        bus.blk_valid = 1'b0;

        // Reset while waiting for a block that is being offered.
        bus.nb_ready = 1'b1;
        @(negedge clk);
        bus.nb_ready = 1'b0;
        check("pre_rst_blk_ready", bus.blk_ready, 1'b1);
        check("pre_rst_state", state_dbg, WAIT_BLK);
        bus.blk_pixels = make_blk(10);
        bus.blk_valid  = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("rst_async_blk_ready", bus.blk_ready, 1'b0);
        check("rst_async_state", state_dbg, PRESENT);
        @(negedge clk);
        bus.blk_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_nb_valid", bus.nb_valid, 1'b1);
        check("post_rst_blk_ready", bus.blk_ready, 1'b0);
        check_mb("post_rst", 0, 0, TOP_DEF, LEFT_DEF);

        // Normal operation resumes after the mid-operation reset.
        send_block(11, 1'b0);
        check_mb("post_rst_mb10", 1, 0, TOP_DEF, {24'd0, p4(179, 183, 187, 191), 8'd128});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
